dds_wave_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-channel full-period sine pROM.
- Holds one shared quarter-wave sine table and one phase accumulator per channel.
- On each sample tick it walks all channels through one pipeline and emits one waveform sample per channel in unsigned offset-binary, for the DAC path.
- Adds per-channel frequency, phase offset, amplitude and waveform mode.

---
 rtl/dds_pkg.sv | 27 ++
 rtl/sin_quarter_rom.sv | 41 ++++
 rtl/dds_wave_gen.sv | 205 ++++++++++++++++++++
 tb/tb_dds_wave_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings and helpers for the DDS waveform generator
package dds_pkg;

  typedef enum logic [1:0] {
    CFG_FTW  = 2'd0,
    CFG_OFS  = 2'd1,
    CFG_AMP  = 2'd2,
    CFG_MODE = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    MODE_SIN = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SAW = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  function automatic int midscale(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// rtl/sin_quarter_rom.sv - quarter-wave sine magnitude table with registered read
// Contents are built at elaboration with a fixed-point Taylor series, so no external hex file is needed.
module sin_quarter_rom #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] ad,
  output logic [DATA_W-2:0] dout
);

  localparam int     DEPTH   = 1 << ADDR_W;
  localparam longint ONE     = 64'sd1073741824;
  localparam longint HALF_PI = 64'sd1686629713;

  // round(A * sin(pi/2 * (i + 0.5) / DEPTH)) in Q30, Horner form up to x^11
  function automatic logic [DATA_W-2:0] sin_entry(input int i);
    longint x, x2, t, full;
    x    = (HALF_PI * longint'(2 * i + 1)) >>> (ADDR_W + 1);
    x2   = (x * x) >>> 30;
    t    = ONE - ((x2 * ONE) >>> 30) / 110;
    t    = ONE - ((x2 * t) >>> 30) / 72;
    t    = ONE - ((x2 * t) >>> 30) / 42;
    t    = ONE - ((x2 * t) >>> 30) / 20;
    t    = ONE - ((x2 * t) >>> 30) / 6;
    full = longint'((64'sd1 <<< (DATA_W - 1)) - 1);
    return (DATA_W-1)'(((((x * t) >>> 30) * full) + (ONE >>> 1)) >>> 30);
  endfunction

  logic [DATA_W-2:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    localparam logic [DATA_W-2:0] VAL = sin_entry(i);
    assign rom_tbl[i] = VAL;
  end

  always_ff @(posedge clk) begin
    dout <= rom_tbl[ad];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - multi-channel DDS sharing one quarter-wave sine table
// Each sample tick sequences every channel through a 5-stage pipeline (issue, fold, ROM, shape, output).
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 32,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int AMP_W    = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               phase_clr,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic               overrun_clr,
  output logic [DATA_W-1:0]  dout,
  output logic [CH_W-1:0]    dout_ch,
  output logic               dout_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int                       IDX_W   = ADDR_W + 2;
  localparam int                       TRI_SH  = ADDR_W - DATA_W + 1;
  localparam int                       PW      = DATA_W + AMP_W + 1;
  localparam logic [DATA_W-1:0]        MID     = DATA_W'(midscale(DATA_W));
  localparam logic signed [DATA_W-1:0] FULL    = DATA_W'(midscale(DATA_W) - 1);
  localparam logic [CH_W-1:0]          LAST_CH = CH_W'(CHANNELS - 1);

  logic [PHASE_W-1:0] acc  [CHANNELS];
  logic [PHASE_W-1:0] ftw  [CHANNELS];
  logic [PHASE_W-1:0] ofs  [CHANNELS];
  logic [AMP_W-1:0]   amp  [CHANNELS];
  logic [1:0]         mode [CHANNELS];

  seq_state_e      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = RUN;
          ch_d    = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (ch_q == LAST_CH) state_d = IDLE;
        else                 ch_d    = ch_q + CH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset)                     overrun <= 1'b0;
    else if (sample_tick && busy)  overrun <= 1'b1;
    else if (overrun_clr)          overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ftw[i]  <= '0;
        ofs[i]  <= '0;
        amp[i]  <= '1;
        mode[i] <= MODE_SIN;
      end
    end else if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
      case (cfg_sel)
        CFG_FTW:  ftw[cfg_ch]  <= cfg_data;
        CFG_OFS:  ofs[cfg_ch]  <= cfg_data;
        CFG_AMP:  amp[cfg_ch]  <= cfg_data[AMP_W-1:0];
        CFG_MODE: mode[cfg_ch] <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || phase_clr) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (issue) begin
      acc[ch_q] <= acc[ch_q] + ftw[ch_q];
    end
  end

  // S0 -> S1: config is captured at issue, so a same-cycle write only affects later samples
  logic              s1_valid;
  logic [CH_W-1:0]   s1_ch;
  logic [IDX_W-1:0]  s1_idx;
  logic [1:0]        s1_mode;
  logic [AMP_W-1:0]  s1_amp;

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= issue;
    s1_ch   <= ch_q;
    s1_idx  <= IDX_W'((acc[ch_q] + ofs[ch_q]) >> (PHASE_W - IDX_W));
    s1_mode <= mode[ch_q];
    s1_amp  <= amp[ch_q];
  end

  logic [1:0]        s1_q;
  logic [ADDR_W-1:0] s1_ae;
  logic [DATA_W-2:0] rom_m;

  assign s1_q  = s1_idx[IDX_W-1 -: 2];
  assign s1_ae = s1_q[0] ? ~s1_idx[ADDR_W-1:0] : s1_idx[ADDR_W-1:0];

  sin_quarter_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk  (clk),
    .ad   (s1_ae),
    .dout (rom_m)
  );

  logic              s2_valid;
  logic [CH_W-1:0]   s2_ch;
  logic              s2_neg;
  logic [DATA_W-2:0] s2_tri;
  logic [DATA_W-1:0] s2_saw;
  logic [1:0]        s2_mode;
  logic [AMP_W-1:0]  s2_amp;

  always_ff @(posedge clk) begin
    if (reset) s2_valid <= 1'b0;
    else       s2_valid <= s1_valid;
    s2_ch   <= s1_ch;
    s2_neg  <= s1_q[1];
    s2_tri  <= (DATA_W-1)'(s1_ae >> TRI_SH);
    s2_saw  <= s1_idx[IDX_W-1 -: DATA_W];
    s2_mode <= s1_mode;
    s2_amp  <= s1_amp;
  end

  logic signed [DATA_W-1:0] shaped, scaled;
  logic signed [PW-1:0]     prod;

  always_comb begin
    shaped = '0;
    case (s2_mode)
      MODE_SIN: shaped = s2_neg ? -$signed({1'b0, rom_m})  : $signed({1'b0, rom_m});
      MODE_TRI: shaped = s2_neg ? -$signed({1'b0, s2_tri}) : $signed({1'b0, s2_tri});
      MODE_SAW: shaped = $signed(s2_saw);
      MODE_SQR: shaped = s2_neg ? -FULL : FULL;
      default: ;
    endcase
    prod   = PW'(shaped) * PW'($signed({1'b0, s2_amp}));
    scaled = DATA_W'(prod >>> AMP_W);
  end

  logic                     s3_valid;
  logic [CH_W-1:0]          s3_ch;
  logic signed [DATA_W-1:0] s3_s;

  always_ff @(posedge clk) begin
    if (reset) s3_valid <= 1'b0;
    else       s3_valid <= s2_valid;
    s3_ch <= s2_ch;
    s3_s  <= (&s2_amp) ? shaped : scaled;
  end

  // dout holds the last sample between passes
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= MID;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s3_valid;
      if (s3_valid) begin
        dout    <= $unsigned(s3_s) + MID;
        dout_ch <= s3_ch;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - scoreboard bench for dds_wave_gen (2 channels, 10-bit table, 8-bit output)
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        phase_clr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        overrun_clr = 1'b0;
  logic [7:0]  dout;
  logic [0:0]  dout_ch;
  logic        dout_valid, busy, overrun;

  dds_wave_gen dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .phase_clr   (phase_clr),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .overrun_clr (overrun_clr),
    .dout        (dout),
    .dout_ch     (dout_ch),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          last_val [2];
  logic [31:0] m_acc [2];
  logic [31:0] m_ftw [2];
  logic [31:0] m_ofs [2];
  logic [7:0]  m_amp [2];
  logic [1:0]  m_mode [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(logic [31:0] ph, logic [1:0] md, logic [7:0] am);
    int  idx, q, a, ae, m, s;
    real pi;
    pi  = 3.141592653589793;
    idx = int'(ph[31:20]);
    q   = idx >> 10;
    a   = idx & 1023;
    ae  = ((q & 1) != 0) ? 1023 - a : a;
    m   = $rtoi(127.0 * $sin(pi / 2.0 * (real'(ae) + 0.5) / 1024.0) + 0.5);
    case (md)
      2'd0: s = ((q & 2) != 0) ? -m : m;
      2'd1: s = ((q & 2) != 0) ? -(ae >> 3) : (ae >> 3);
      2'd2: begin
        s = idx >> 4;
        if (s > 127) s = s - 256;
      end
      default: s = ((q & 2) != 0) ? -127 : 127;
    endcase
    if (am != 8'hFF) s = $rtoi($floor(real'(s * int'(am)) / 256.0));
    return (s + 128) & 255;
  endfunction

  always @(negedge clk) begin
    if (!reset && dout_valid) begin
      valid_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        $display("FAIL unexpected_valid: ch=%0d dout=%02h at cycle %0d, required no sample", dout_ch, dout, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (int'(dout) !== mon_e.val || int'(dout_ch) !== mon_e.ch || cyc !== mon_e.cyc)
          $display("FAIL sample: got ch=%0d dout=%02h cycle=%0d, required ch=%0d dout=%02h cycle=%0d",
                   dout_ch, dout, cyc, mon_e.ch, mon_e.val, mon_e.cyc);
        else
          passed++;
        last_val[dout_ch] = int'(dout);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0; m_ftw[k] = '0; m_ofs[k] = '0; m_amp[k] = 8'hFF; m_mode[k] = 2'd0;
      last_val[k] = -1;
    end
  endtask

  task automatic model_cfg(int ch, logic [1:0] sel, logic [31:0] data);
    case (sel)
      2'd0: m_ftw[ch] = data;
      2'd1: m_ofs[ch] = data;
      2'd2: m_amp[ch] = data[7:0];
      default: m_mode[ch] = data[1:0];
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(int ch, logic [1:0] sel, logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_sel = sel; cfg_data = data;
    model_cfg(ch, sel, data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_pass();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.ch  = k;
      e.val = model(m_acc[k] + m_ofs[k], m_mode[k], m_amp[k]);
      e.cyc = cyc + 5 + k;
      sbq.push_back(e);
      m_acc[k] = m_acc[k] + m_ftw[k];
    end
  endtask

  // returns at the negedge of cycle T+1
  task automatic do_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    last_val[0] = -1;
    last_val[1] = -1;
    push_pass();
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL drain_timeout: %0d samples pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  task automatic test_reset();
    int v0;
    do_reset();
    checks++; if (dout !== 8'h80) $display("FAIL reset_dout: got %02h, required 80", dout); else passed++;
    checks++; if (dout_ch !== 1'b0) $display("FAIL reset_dout_ch: got %0d, required 0", dout_ch); else passed++;
    checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", dout_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b, required 0", overrun); else passed++;
    v0 = valid_cnt;
    do_tick();
    checks++; if (busy !== 1'b1) $display("FAIL busy_t1: got %0b, required 1", busy); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL busy_t2: got %0b, required 1", busy); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL busy_t3: got %0b, required 0", busy); else passed++;
    drain();
    checks++;
    if (valid_cnt - v0 !== 2) $display("FAIL valid_count: got %0d, required 2", valid_cnt - v0); else passed++;
  endtask

  task automatic test_ftw_and_amp(logic [7:0] am, int e0, int e1, int e2, int e3);
    int exp0 [4];
    exp0 = '{e0, e1, e2, e3};
    do_reset();
    cfg_write(0, 2'd0, 32'h4000_0000);
    cfg_write(0, 2'd2, {24'h0, am});
    for (int i = 0; i < 4; i++) begin
      do_tick();
      drain();
      checks++;
      if (last_val[0] !== exp0[i]) $display("FAIL ftw_amp%02h_ch0_%0d: got %02h, required %02h", am, i, last_val[0], exp0[i]);
      else passed++;
      checks++;
      if (last_val[1] !== 'h80) $display("FAIL ftw_amp%02h_ch1_%0d: got %02h, required 80", am, i, last_val[1]);
      else passed++;
    end
  endtask

  task automatic test_modes();
    do_reset();
    cfg_write(0, 2'd3, 32'd3);
    do_tick(); drain();
    checks++; if (last_val[0] !== 'hFF) $display("FAIL square_pos: got %02h, required FF", last_val[0]); else passed++;
    cfg_write(0, 2'd1, 32'h8000_0000);
    do_tick(); drain();
    checks++; if (last_val[0] !== 'h01) $display("FAIL square_neg: got %02h, required 01", last_val[0]); else passed++;
    cfg_write(0, 2'd3, 32'd2);
    cfg_write(0, 2'd1, 32'h4000_0000);
    do_tick(); drain();
    checks++; if (last_val[0] !== 'hC0) $display("FAIL sawtooth: got %02h, required C0", last_val[0]); else passed++;
    cfg_write(0, 2'd3, 32'd1);
    cfg_write(0, 2'd1, 32'h3000_0000);
    do_tick(); drain();
    checks++; if (last_val[0] !== 'hE0) $display("FAIL triangle: got %02h, required E0", last_val[0]); else passed++;
  endtask

  task automatic test_cfg_collision();
    do_reset();
    do_tick();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_sel = 2'd3; cfg_data = 32'd3;
    model_cfg(0, 2'd3, 32'd3);
    @(negedge clk);
    cfg_we = 1'b0;
    drain();
    checks++; if (last_val[0] !== 'h80) $display("FAIL collision_old: got %02h, required 80", last_val[0]); else passed++;
    do_tick(); drain();
    checks++; if (last_val[0] !== 'hFF) $display("FAIL collision_new: got %02h, required FF", last_val[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = valid_cnt;
    do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %0b, required 1", overrun); else passed++;
    @(negedge clk);
    @(negedge clk);
    overrun_clr = 1'b1;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0b, required 1", overrun); else passed++;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) $display("FAIL overrun_clr: got %0b, required 0", overrun); else passed++;
    drain();
    checks++; if (valid_cnt - v0 !== 2) $display("FAIL overrun_valids: got %0d, required 2", valid_cnt - v0); else passed++;
    do_tick();
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_set_wins: got %0b, required 1", overrun); else passed++;
    drain();
  endtask

  task automatic test_reset_mid_pass();
    int v0;
    do_reset();
    cfg_write(0, 2'd3, 32'd3);
    cfg_write(1, 2'd3, 32'd3);
    do_tick(); drain();
    do_tick();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    model_reset();
    v0 = valid_cnt;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (dout !== 8'h80) $display("FAIL midreset_dout: got %02h, required 80", dout); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %0b, required 0", busy); else passed++;
    repeat (8) @(negedge clk);
    checks++; if (valid_cnt !== v0) $display("FAIL midreset_valids: got %0d, required 0", valid_cnt - v0); else passed++;
  endtask

  task automatic test_phase_clr();
    do_reset();
    cfg_write(0, 2'd0, 32'h1000_0000);
    cfg_write(0, 2'd1, 32'h0800_0000);
    cfg_write(0, 2'd3, 32'd2);
    cfg_write(1, 2'd0, 32'h2000_0000);
    cfg_write(1, 2'd3, 32'd2);
    do_tick(); drain();
    do_tick(); drain();
    do_tick();
    @(negedge clk);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    m_acc[0] = '0;
    m_acc[1] = '0;
    drain();
    do_tick(); drain();
    checks++; if (last_val[0] !== 'h88) $display("FAIL phase_clr_ch0: got %02h, required 88", last_val[0]); else passed++;
    checks++; if (last_val[1] !== 'h80) $display("FAIL phase_clr_ch1: got %02h, required 80", last_val[1]); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ftw_and_amp(8'hFF, 'h80, 'hFF, 'h80, 'h01);
    test_ftw_and_amp(8'h80, 'h80, 'hBF, 'h80, 'h40);
    test_modes();
    test_cfg_collision();
    test_back_to_back();
    test_reset_mid_pass();
    test_phase_clr();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
